join_n_buffered: RTL and testbench

Parametrised N-input handshake join with per-channel elastic buffering and a registered output stage. Each input channel is captured independently into its own small FIFO, so an early producer is not stalled until its buffer fills. One output beat, the concatenation of one word from every channel, is emitted once all channels hold data. It sits between independently-timed producer streams (e.g. activation and weight streams) and a consumer that needs them aligned. It replaces combinational two-input joins wherever inputs are skewed or timing paths must be cut.

---
 rtl/join_n_buffered_pkg.sv | 13 +
 rtl/join_n_fifo.sv | 72 +++++++
 rtl/join_n_buffered.sv | 76 +++++++
 tb/tb_join_n_buffered.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/join_n_buffered_pkg.sv
// Shared width helpers for the buffered N-input join and its per-channel FIFO.
package join_n_buffered_pkg;

    // Count must be able to represent the full value DEPTH.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/join_n_fifo.sv
// Single-channel circular buffer with occupancy count and a registered ready flag.
module join_n_fifo
    import join_n_buffered_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  not_empty,
    output logic                  ready
);

    localparam int unsigned CntW = cnt_width(DEPTH);
    localparam int unsigned PtrW = ptr_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  ready_q, ready_d;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        // Ready is registered, so it cannot observe a pop in the same edge.
        ready_d = (count_d < CntW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign ready     = ready_q;

    push_when_full_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_q == CntW'(DEPTH))));

endmodule

// File: rtl/join_n_buffered.sv
// N-input handshake join: per-channel FIFOs feed a registered, AXI-style output stage.
module join_n_buffered
    import join_n_buffered_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_INPUTS-1:0]            valid_in,
    output logic [NUM_INPUTS-1:0]            ready_in,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] data_out,
    output logic                             valid_out,
    input  logic                             ready_out
);

    logic [NUM_INPUTS-1:0]            push;
    logic [NUM_INPUTS-1:0]            not_empty;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] heads;
    logic                             all_avail;
    logic                             load;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                             valid_out_q, valid_out_d;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        assign push[i] = valid_in[i] & ready_in[i];

        join_n_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[i]),
            .data_in   (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop       (load),
            .head      (heads[i*DATA_WIDTH +: DATA_WIDTH]),
            .not_empty (not_empty[i]),
            .ready     (ready_in[i])
        );
    end

    assign all_avail = &not_empty;
    assign load      = all_avail & (~valid_out_q | ready_out);

    always_comb begin
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        if (load) begin
            data_out_d  = heads;
            valid_out_d = 1'b1;
        end else if (ready_out && valid_out_q) begin
            valid_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

    // A stalled beat must not change until the consumer takes it.
    hold_under_backpressure_a : assert property (@(posedge clk) disable iff (!rst_n)
        (valid_out_q && !ready_out) |=> (valid_out_q && $stable(data_out_q)));

endmodule

// File: tb/tb_join_n_buffered.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_join_n_buffered;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int D  = 2;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    valid_in;
    logic [N-1:0]    ready_in;
    logic [N*DW-1:0] data_out;
    logic            valid_out;
    logic            ready_out;

    logic [2*DW-1:0] d1_data_in   = 16'h5A3C;
    logic [1:0]      d1_valid_in  = 2'b11;
    logic [1:0]      d1_ready_in;
    logic [2*DW-1:0] d1_data_out;
    logic            d1_valid_out;
    logic            d1_ready_out = 1'b1;

    always #5 clk = ~clk;

    join_n_buffered #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .DEPTH(D)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    join_n_buffered #(.NUM_INPUTS(2), .DATA_WIDTH(DW), .DEPTH(1)) u_dut_d1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (d1_data_in),
        .valid_in  (d1_valid_in),
        .ready_in  (d1_ready_in),
        .data_out  (d1_data_out),
        .valid_out (d1_valid_out),
        .ready_out (d1_ready_out)
    );

    // Reference model: one queue per channel plus the visible output register.
    logic [DW-1:0]   mq [N][$];
    logic [N-1:0]    m_ready;
    logic            m_vo;
    logic [N*DW-1:0] m_do;
    logic [N*DW-1:0] got [$];
    int              d1_beats;
    int              errors = 0;
    int              checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_ready = '0;
        m_vo    = 1'b0;
        m_do    = '0;
    endtask

    // One clock: log consumed beats, advance the model at the edge, compare 1 time unit later.
    task automatic step(input string tag);
        logic all_av;
        if (valid_out && ready_out) got.push_back(data_out);
        if (d1_valid_out && d1_ready_out) d1_beats++;
        @(posedge clk);
        all_av = 1'b1;
        for (int i = 0; i < N; i++) if (mq[i].size() == 0) all_av = 1'b0;
        if (all_av && (!m_vo || ready_out)) begin
            for (int i = 0; i < N; i++) m_do[i*DW +: DW] = mq[i].pop_front();
            m_vo = 1'b1;
        end else if (m_vo && ready_out) begin
            m_vo = 1'b0;
        end
        for (int i = 0; i < N; i++) if (valid_in[i] && m_ready[i]) mq[i].push_back(data_in[i*DW +: DW]);
        for (int i = 0; i < N; i++) m_ready[i] = (mq[i].size() < D);
        #1;
        check({tag, ".ready_in"},  32'(ready_in),  32'(m_ready));
        check({tag, ".valid_out"}, 32'(valid_out), 32'(m_vo));
        check({tag, ".data_out"},  32'(data_out),  32'(m_do));
    endtask

    initial begin
        model_reset();
        data_in   = '0;
        valid_in  = '0;
        ready_out = 1'b0;

        // Reset release
        #27 rst_n = 1'b1;
        #1;
        check("rel0.ready_in",  32'(ready_in),  32'(3'b000));
        check("rel0.valid_out", 32'(valid_out), 32'(0));
        check("rel0.data_out",  32'(data_out),  32'(0));
        step("rel1");
        check("rel1.all_ready", 32'(ready_in), 32'(3'b111));

        // Aligned stream
        got.delete();
        ready_out = 1'b1;
        for (int k = 0; k < 8; k++) begin
            valid_in = '1;
            for (int i = 0; i < N; i++) data_in[i*DW +: DW] = 8'(i * 16 + k);
            step("aln");
        end
        valid_in = '0;
        repeat (4) step("aln_drain");
        check("aln.beats", 32'(got.size()), 32'(8));
        for (int k = 0; k < 8; k++)
            check("aln.order", 32'(got[k]), 32'({8'(32 + k), 8'(16 + k), 8'(k)}));

        // Backpressure
        got.delete();
        ready_out = 1'b0;
        valid_in  = '1;
        for (int c = 0; c < 6; c++) begin
            data_in = 24'($urandom);
            step("bp");
        end
        check("bp.all_full", 32'(ready_in),  32'(3'b000));
        check("bp.pending",  32'(valid_out), 32'(1));
        valid_in  = '0;
        ready_out = 1'b1;
        repeat (6) step("bp_drain");
        check("bp.beats", 32'(got.size()), 32'(3));

        // Skew: channel 0 runs ahead of channels 1 and 2
        got.delete();
        valid_in = 3'b001;
        data_in  = 24'h00000A;
        step("skew");
        data_in = 24'h00000B;
        step("skew");
        check("skew.ch0_stall", 32'(ready_in[0]), 32'(0));
        data_in = 24'h00000C;
        step("skew");
        step("skew");
        valid_in = 3'b111;
        data_in  = 24'h01010C;
        step("skew");
        data_in = 24'h02020C;
        step("skew");
        valid_in = 3'b001;
        step("skew");
        valid_in = '0;
        repeat (4) step("skew_drain");
        check("skew.beats", 32'(got.size()), 32'(2));
        check("skew.beat0", 32'(got[0]), 32'(24'h01010A));
        check("skew.beat1", 32'(got[1]), 32'(24'h02020B));

        // Mid-transfer reset
        ready_out = 1'b0;
        valid_in  = '1;
        data_in   = 24'($urandom);
        step("mrst_fill");
        data_in = 24'($urandom);
        step("mrst_fill");
        valid_in = '0;
        check("mrst.pre_valid", 32'(valid_out), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mrst.valid_out", 32'(valid_out), 32'(0));
        check("mrst.data_out",  32'(data_out),  32'(0));
        check("mrst.ready_in",  32'(ready_in),  32'(0));
        model_reset();
        #3 rst_n = 1'b1;
        got.delete();
        ready_out = 1'b1;
        repeat (4) step("mrst_post");
        check("mrst.no_stale", 32'(got.size()), 32'(0));

        // Random traffic; the DEPTH=1 instance is measured over the first 20 cycles
        d1_beats = 0;
        for (int c = 0; c < 200; c++) begin
            valid_in  = 3'($urandom);
            data_in   = 24'($urandom);
            ready_out = ($urandom_range(0, 3) != 0);
            step("rnd");
            if (c == 19) check("d1.throughput", 32'(d1_beats), 32'(10));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
